pool_stream_ctrl: RTL and testbench



---
 rtl/pool_stream_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pool_stream_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream_ctrl.sv
// pool_stream_ctrl
// Flow controller between the convolution output stream and the 2x2 pooling
// line-buffer datapath. Pixels are forwarded one line at a time. A new line
// is only started when a pool line buffer is free (a credit), so back-pressure
// appears only at line boundaries. Pooled row pairs reported by the datapath
// return two credits each and are counted toward frame completion.
module pool_stream_ctrl #(
  parameter int LINE_PIXELS = 510,
  parameter int FRAME_LINES = 510,
  parameter int NUM_LB      = 4,
  parameter int DATA_W      = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_pool_data,
  output logic              o_pool_data_valid,
  input  logic              i_pool_intr,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [8:0]        o_rows_pooled,
  output logic              o_err
);

  localparam int PIX_W  = $clog2(LINE_PIXELS);
  localparam int LINE_W = $clog2(FRAME_LINES + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIXELS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [8:0]        ROWS_MAX  = 9'(FRAME_LINES / 2);
  localparam logic [2:0]        CRED_MAX  = 3'(NUM_LB);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
  logic [2:0]          credits_q, credits_d;
  logic [8:0]          rows_q, rows_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   pool_data_q, pool_data_d;
  logic                pool_valid_q, pool_valid_d;

  logic                in_ready;
  logic                xfer;
  logic                line_start;
  logic [3:0]          cred_sum;

  // State and counter registers; everything returns to its idle value on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      credits_q    <= CRED_MAX;
      rows_q       <= '0;
      err_q        <= 1'b0;
      pool_data_q  <= '0;
      pool_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      credits_q    <= credits_d;
      rows_q       <= rows_d;
      err_q        <= err_d;
      pool_data_q  <= pool_data_d;
      pool_valid_q <= pool_valid_d;
    end
  end

  // Next-state logic: handshake, line/credit bookkeeping and frame sequencing.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    credits_d    = credits_q;
    rows_d       = rows_q;
    err_d        = err_q;
    pool_data_d  = pool_data_q;
    pool_valid_d = 1'b0;

    // Mid-line pixels are always accepted; a new line needs a free buffer.
    in_ready   = (state_q == ST_RUN) && ((pix_cnt_q != '0) || (credits_q != 3'd0));
    xfer       = in_ready && i_in_valid;
    line_start = xfer && (pix_cnt_q == '0);

    // A line start implies credits_q >= 1, so this never underflows.
    cred_sum = {1'b0, credits_q}
             + (i_pool_intr ? 4'd2 : 4'd0)
             - (line_start  ? 4'd1 : 4'd0);

    if (xfer) begin
      pool_data_d  = i_in_data;
      pool_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          rows_d     = '0;
          err_d      = 1'b0;
          credits_d  = CRED_MAX;
          state_d    = ST_RUN;
        end
        // A pooled pair with no frame in flight is a protocol error.
        if (i_pool_intr) begin
          err_d = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (cred_sum > {1'b0, CRED_MAX}) begin
          credits_d = CRED_MAX;
          err_d     = 1'b1;
        end else begin
          credits_d = cred_sum[2:0];
        end

        if (i_pool_intr) begin
          if (rows_q < ROWS_MAX) begin
            rows_d = rows_q + 9'd1;
          end else begin
            err_d = 1'b1;
          end
        end

        if (state_q == ST_RUN) begin
          if (xfer) begin
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d  = '0;
              line_cnt_d = line_cnt_q + LINE_W'(1);
              if (line_cnt_q == LINE_LAST) begin
                state_d = ST_DRAIN;
              end
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end
        end else if (rows_q == ROWS_MAX) begin
          state_d = ST_DONE;
        end
      end

      default: begin
        if (i_pool_intr) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_in_ready        = in_ready;
  assign o_pool_data       = pool_data_q;
  assign o_pool_data_valid = pool_valid_q;
  assign o_busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_frame_done      = (state_q == ST_DONE);
  assign o_rows_pooled     = rows_q;
  assign o_err             = err_q;

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Bench for pool_stream_ctrl with a reduced frame (12 x 10) so whole frames
// fit in a short run. A transaction-level model tracks total pixels accepted
// this frame, free buffers, pooled pairs and the error flag; every cycle the
// DUT outputs are compared against it, and literal counts pin the model.
module tb_pool_stream_ctrl;

  localparam int LP  = 12;
  localparam int FL  = 10;
  localparam int NLB = 4;
  localparam int DW  = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          intr = 1'b0;
  logic          o_in_ready;
  logic [DW-1:0] o_pool_data;
  logic          o_pool_data_valid;
  logic          o_busy;
  logic          o_frame_done;
  logic [8:0]    o_rows_pooled;
  logic          o_err;

  always #5 clk = ~clk;

  pool_stream_ctrl #(
    .LINE_PIXELS(LP),
    .FRAME_LINES(FL),
    .NUM_LB(NLB),
    .DATA_W(DW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_in_data(in_data),
    .i_in_valid(in_valid),
    .o_in_ready(o_in_ready),
    .o_pool_data(o_pool_data),
    .o_pool_data_valid(o_pool_data_valid),
    .i_pool_intr(intr),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done),
    .o_rows_pooled(o_rows_pooled),
    .o_err(o_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 drain, 3 done.
  int            m_phase = 0;
  int            m_xf    = 0;
  int            m_cred  = NLB;
  int            m_rows  = 0;
  bit            m_err   = 1'b0;
  bit            m_pv    = 1'b0;
  logic [DW-1:0] m_pd    = '0;

  int cyc_n = 0;
  int due_q[$];
  bit auto_intr = 1'b0;
  bit late_last = 1'b0;
  int beats = 0;
  int done_cnt = 0;

  function automatic bit m_ready();
    return (m_phase == 1) && (((m_xf % LP) != 0) || (m_cred > 0));
  endfunction

  // Model update, one step per clock edge.
  always @(posedge clk) begin
    automatic bit xf;
    automatic int np, nx, nc, nr;
    automatic bit ne;
    cyc_n <= cyc_n + 1;
    if (rst) begin
      m_phase <= 0; m_xf <= 0; m_cred <= NLB; m_rows <= 0;
      m_err <= 1'b0; m_pv <= 1'b0; m_pd <= '0;
      due_q.delete();
    end else begin
      xf = m_ready() && in_valid;
      m_pv <= xf;
      if (xf) m_pd <= in_data;
      np = m_phase; nx = m_xf; nc = m_cred; nr = m_rows; ne = m_err;
      case (m_phase)
        0: begin
          if (start) begin np = 1; nx = 0; nc = NLB; nr = 0; ne = 1'b0; end
          if (intr) ne = 1'b1;
        end
        1, 2: begin
          nc = m_cred + (intr ? 2 : 0) - ((xf && (m_xf % LP) == 0) ? 1 : 0);
          if (nc > NLB) begin nc = NLB; ne = 1'b1; end
          if (intr) begin
            if (m_rows < FL / 2) nr = m_rows + 1;
            else ne = 1'b1;
          end
          if (m_phase == 1 && xf) begin
            nx = m_xf + 1;
            if (auto_intr && (nx % LP) == 0 && ((nx / LP) % 2) == 0)
              due_q.push_back(cyc_n + 3 + ((late_last && nx == LP * FL) ? 50 : 0));
            if (nx == LP * FL) np = 2;
          end
          if (m_phase == 2 && m_rows == FL / 2) np = 3;
        end
        default: begin
          if (intr) ne = 1'b1;
          np = 0;
        end
      endcase
      m_phase <= np; m_xf <= nx; m_cred <= nc; m_rows <= nr; m_err <= ne;
    end
  end

  // Automatic pooled-pair reports from the scheduled queue.
  always @(negedge clk) begin
    if (auto_intr) begin
      if (due_q.size() > 0 && due_q[0] <= cyc_n) begin
        intr = 1'b1;
        void'(due_q.pop_front());
      end else begin
        intr = 1'b0;
      end
    end
  end

  // Fresh random pixel data every cycle.
  always @(negedge clk) in_data = DW'($urandom);

  // Per-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    chk("in_ready", o_in_ready, m_ready());
    chk("pool_valid", o_pool_data_valid, m_pv);
    if (m_pv) chk("pool_data", o_pool_data, m_pd);
    chk("busy", o_busy, (m_phase == 1 || m_phase == 2));
    chk("frame_done", o_frame_done, (m_phase == 3));
    chk("rows_pooled", o_rows_pooled, m_rows);
    chk("err", o_err, m_err);
    if (o_pool_data_valid) beats++;
    if (o_frame_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_intr();
    intr = 1'b1; tick(1); intr = 1'b0;
  endtask

  int b0, d0;

  initial begin
    // Reset values.
    tick(3);
    chk("rst_ready", o_in_ready, 0);
    chk("rst_valid", o_pool_data_valid, 0);
    chk("rst_data", o_pool_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rows", o_rows_pooled, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0;
    tick(1);
    $display("txn: reset released");

    // Full frame, back-to-back pixels, pairs reported 3 cycles after even lines.
    auto_intr = 1'b1; late_last = 1'b0;
    b0 = beats; d0 = done_cnt;
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) tick(1);
    in_valid = 1'b0;
    tick(2);
    auto_intr = 1'b0; intr = 1'b0;
    chk("f1_beats", beats - b0, 120);
    chk("f1_rows", o_rows_pooled, 5);
    chk("f1_done", done_cnt - d0, 1);
    chk("f1_err", o_err, 0);
    $display("txn: frame1 beats=%0d done=%0d", beats - b0, done_cnt - d0);

    // No pairs reported: four lines, then stall; one report -> two more lines.
    b0 = beats;
    pulse_start();
    in_valid = 1'b1;
    tick(100);
    chk("t2_stall_beats", beats - b0, 48);
    chk("t2_stall_ready", o_in_ready, 0);
    pulse_intr();
    tick(100);
    chk("t2_more_beats", beats - b0, 72);
    chk("t2_ready2", o_in_ready, 0);
    $display("txn: stall test beats=%0d", beats - b0);

    // Pair report coincident with a line-start transfer at one credit.
    in_valid = 1'b0;
    b0 = beats; d0 = done_cnt;
    pulse_intr();
    in_valid = 1'b1;
    tick(12);
    intr = 1'b1; tick(1); intr = 1'b0;
    tick(35);
    in_valid = 1'b0;
    tick(2);
    chk("t3_beats", beats - b0, 48);
    chk("t3_drain_busy", o_busy, 1);
    chk("t3_drain_ready", o_in_ready, 0);
    chk("t3_rows", o_rows_pooled, 3);
    $display("txn: coincident intr beats=%0d", beats - b0);

    // Drain with the final report arriving late.
    pulse_intr();
    tick(50);
    chk("t3_no_early_done", done_cnt - d0, 0);
    chk("t3_busy_wait", o_busy, 1);
    pulse_intr();
    tick(5);
    chk("t3_done_once", done_cnt - d0, 1);
    chk("t3_idle_busy", o_busy, 0);
    chk("t3_rows_final", o_rows_pooled, 5);
    $display("txn: late drain done=%0d", done_cnt - d0);

    // Report while idle flags an error; start clears it.
    pulse_intr();
    tick(1);
    chk("idle_intr_err", o_err, 1);
    pulse_start();
    chk("start_clears_err", o_err, 0);
    chk("start_ready", o_in_ready, 1);
    $display("txn: idle intr err / start clear");

    // Credit overflow in RUN: saturates, sets error, lines still flow.
    repeat (3) begin pulse_intr(); tick(1); end
    chk("ovf_err", o_err, 1);
    chk("ovf_rows", o_rows_pooled, 3);
    b0 = beats; d0 = done_cnt;
    in_valid = 1'b1;
    tick(30);
    in_valid = 1'b0;
    tick(1);
    chk("ovf_beats", beats - b0, 30);
    $display("txn: overflow err=%0d", o_err);

    // Reset mid-line.
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mrst_ready", o_in_ready, 0);
    chk("mrst_valid", o_pool_data_valid, 0);
    chk("mrst_data", o_pool_data, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_rows", o_rows_pooled, 0);
    chk("mrst_err", o_err, 0);
    chk("mrst_no_done", done_cnt - d0, 0);
    $display("txn: mid-line reset");

    // Random valid gaps, last pair reported 50 cycles late.
    tick(1);
    auto_intr = 1'b1; late_last = 1'b1;
    b0 = beats; d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      tick(1);
    end
    in_valid = 1'b0;
    tick(3);
    auto_intr = 1'b0; intr = 1'b0;
    chk("f2_beats", beats - b0, 120);
    chk("f2_done", done_cnt - d0, 1);
    chk("f2_rows", o_rows_pooled, 5);
    chk("f2_err", o_err, 0);
    chk("f2_busy", o_busy, 0);
    $display("txn: frame2 beats=%0d done=%0d", beats - b0, done_cnt - d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
